// File: rtl/radio_tx_framer.sv
// radio_tx_framer
// Buffers payload bytes pushed by the controller and serializes them as one
// framed packet on a single bit line toward the RF front end.
// Frame: PREAMBLE, SYNC, N, N payload bytes, checksum = (N + sum) mod 256.
// Bytes go out LSB first, each bit held CLKS_PER_BIT cycles, with no gaps.
//
// Handshake: a byte is taken on any cycle where radio_send && !radio_busy.
// A push seen while radio_busy is high is dropped; there is no retry.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   radio_enable   : low aborts any frame, clears the buffer, blocks pushes
//   radio_send     : push strobe, one byte per cycle
//   radio_tx_data  : payload byte sampled with radio_send
//   radio_busy     : push refused while high
//   tx_bit         : serial line, idles at 0
//   tx_active      : high while a frame is on the line
//   tx_done        : one-cycle pulse after the final checksum bit
//   dbg_state      : current FSM state encoding, for observation only
module radio_tx_framer #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          MAX_LEN      = 16,
    parameter int          IDLE_TIMEOUT = 32,
    parameter logic [7:0]  PREAMBLE     = 8'hAA,
    parameter logic [7:0]  SYNC         = 8'h7E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       radio_enable,
    input  logic       radio_send,
    input  logic [7:0] radio_tx_data,
    output logic       radio_busy,
    output logic       tx_bit,
    output logic       tx_active,
    output logic       tx_done,
    output logic [2:0] dbg_state
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] L_CPB_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] L_TO_M1  = TW'(IDLE_TIMEOUT - 1);
    localparam logic [7:0]    L_MAX    = 8'(MAX_LEN);
    localparam logic [7:0]    L_MAX_M1 = 8'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_SYNC = 3'd2,
        S_LEN  = 3'd3,
        S_PAY  = 3'd4,
        S_CHK  = 3'd5
    } state_t;

    state_t        r_state;
    logic [7:0]    r_count;
    logic [7:0]    r_sum;
    logic [TW-1:0] r_timer;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte_idx;
    logic          r_tx_bit;
    logic          r_tx_active;
    logic          r_tx_done;
    logic [7:0]    r_buf [0:MAX_LEN-1];

    logic          w_push;
    logic          w_bit_end;
    logic          w_launch;
    logic [7:0]    w_check;
    logic [7:0]    w_next_byte;
    state_t        w_next_state;

    assign radio_busy = !radio_enable || (r_state != S_IDLE) || (r_count == L_MAX);
    assign w_push     = radio_send && !radio_busy;
    assign w_bit_end  = (r_clk_cnt == L_CPB_M1);
    assign w_check    = r_count + r_sum;

    // Launch when the push in flight fills the buffer, when the buffer is
    // already full, or when the idle timer is about to reach the timeout.
    // A push in the same cycle always restarts the timer instead.
    assign w_launch = (w_push && (r_count == L_MAX_M1)) ||
                      (r_count == L_MAX) ||
                      (!w_push && (r_count != 8'd0) && (r_timer == L_TO_M1));

    // Byte that follows the one currently on the line.
    always_comb begin
        w_next_byte  = 8'h00;
        w_next_state = S_IDLE;
        case (r_state)
            S_PRE: begin
                w_next_byte  = SYNC;
                w_next_state = S_SYNC;
            end
            S_SYNC: begin
                w_next_byte  = r_count;
                w_next_state = S_LEN;
            end
            S_LEN: begin
                w_next_byte  = r_buf[0];
                w_next_state = S_PAY;
            end
            S_PAY: begin
                if (r_byte_idx == r_count) begin
                    w_next_byte  = w_check;
                    w_next_state = S_CHK;
                end else begin
                    w_next_byte  = r_buf[r_byte_idx[AW-1:0]];
                    w_next_state = S_PAY;
                end
            end
            default: begin
                w_next_byte  = 8'h00;
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !radio_enable) begin
            r_state     <= S_IDLE;
            r_count     <= 8'd0;
            r_sum       <= 8'd0;
            r_timer     <= '0;
            r_clk_cnt   <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_byte_idx  <= 8'd0;
            r_tx_bit    <= 1'b0;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_push) begin
                    r_buf[r_count[AW-1:0]] <= radio_tx_data;
                    r_count <= r_count + 8'd1;
                    r_sum   <= r_sum + radio_tx_data;
                    r_timer <= '0;
                end else if (r_count != 8'd0) begin
                    r_timer <= r_timer + 1'b1;
                end
                if (w_launch) begin
                    r_state     <= S_PRE;
                    r_shift     <= PREAMBLE;
                    r_tx_bit    <= PREAMBLE[0];
                    r_tx_active <= 1'b1;
                    r_clk_cnt   <= '0;
                    r_bit_idx   <= 3'd0;
                    r_timer     <= '0;
                end
            end else if (!w_bit_end) begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end else begin
                r_clk_cnt <= '0;
                if (r_bit_idx != 3'd7) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                    r_shift   <= r_shift >> 1;
                    r_tx_bit  <= r_shift[1];
                end else begin
                    r_bit_idx <= 3'd0;
                    if (r_state == S_CHK) begin
                        // Last checksum bit finished: frame complete.
                        r_state     <= S_IDLE;
                        r_tx_active <= 1'b0;
                        r_tx_bit    <= 1'b0;
                        r_tx_done   <= 1'b1;
                        r_count     <= 8'd0;
                        r_sum       <= 8'd0;
                        r_shift     <= 8'h00;
                        r_byte_idx  <= 8'd0;
                    end else begin
                        r_state  <= w_next_state;
                        r_shift  <= w_next_byte;
                        r_tx_bit <= w_next_byte[0];
                        if (r_state == S_LEN) begin
                            r_byte_idx <= 8'd1;
                        end else if (r_state == S_PAY) begin
                            r_byte_idx <= r_byte_idx + 8'd1;
                        end
                    end
                end
            end
        end
    end

    assign tx_bit    = r_tx_bit;
    assign tx_active = r_tx_active;
    assign tx_done   = r_tx_done;
    assign dbg_state = r_state;

endmodule
